spi_memory_initiator: RTL and testbench

- Initiator side of the two-byte-address SPI memory protocol; the slave memory controller on the suit FPGA is the responder.
- Accepts one burst request (read or write, start address, length) and drives an existing SPI master byte engine: chip select, address bytes, dummy byte, then data bytes.
- Streams write data in and read data out.
- Used by the host-side/bridge FPGA logic and by the bench as the protocol driver for the slave.

---
 rtl/spi_memory_pkg.sv | 36 +++
 rtl/spi_memory_initiator.sv | 189 ++++++++++++++++++
 tb/tb_spi_memory_initiator.sv | 359 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_memory_pkg.sv
// Shared definitions for the two-byte-address SPI memory protocol,
// imported by both the initiator and the slave-side controller.
package spi_memory_pkg;

    localparam int unsigned WRITE_FLAG_BIT  = 7;
    localparam int unsigned PROTO_ADDR_BITS = 15;
    localparam logic [7:0]  DUMMY_BYTE      = 8'h00;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CS_SETUP,
        ST_ADDR_HI,
        ST_ADDR_LO,
        ST_DUMMY,
        ST_DATA,
        ST_CS_GAP
    } state_t;

    // Burst header as it travels on the wire: direction flag plus 15-bit address
    typedef struct packed {
        logic                       write;
        logic [PROTO_ADDR_BITS-1:0] addr;
    } proto_hdr_t;

    function automatic logic [7:0] proto_byte0(input proto_hdr_t hdr);
        logic [7:0] b;
        b = {1'b0, hdr.addr[PROTO_ADDR_BITS-1:8]};
        b[WRITE_FLAG_BIT] = hdr.write;
        return b;
    endfunction

    function automatic logic [7:0] proto_byte1(input proto_hdr_t hdr);
        return hdr.addr[7:0];
    endfunction

endpackage

// File: rtl/spi_memory_initiator.sv
// Burst initiator for the SPI memory protocol: sequences chip select, address,
// dummy and data bytes through an external byte-exchange engine.
module spi_memory_initiator
    import spi_memory_pkg::*;
#(
    parameter int unsigned ADDRESS_WIDTH   = 13,
    parameter int unsigned LEN_WIDTH       = 8,
    parameter int unsigned CS_SETUP_CYCLES = 2,
    parameter int unsigned CS_IDLE_CYCLES  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_write,
    input  logic [ADDRESS_WIDTH-1:0] req_addr,
    input  logic [LEN_WIDTH-1:0]     req_len,
    input  logic [7:0]               wr_data,
    input  logic                     wr_valid,
    output logic                     wr_ready,
    output logic [7:0]               rd_data,
    output logic                     rd_valid,
    output logic                     busy,
    output logic                     spi_cs,
    output logic                     spi_start,
    output logic [7:0]               spi_tx_data,
    input  logic [7:0]               spi_rx_data,
    input  logic                     spi_done
);

    localparam int unsigned CNT_MAX = (CS_SETUP_CYCLES > CS_IDLE_CYCLES) ?
                                      CS_SETUP_CYCLES : CS_IDLE_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    state_t               state, state_n;
    logic [CNT_W-1:0]     phase_cnt, phase_cnt_n;
    logic [LEN_WIDTH-1:0] len_cnt, len_cnt_n;
    proto_hdr_t           hdr, hdr_n;
    logic                 pending, pending_n;

    logic                 req_ready_n, wr_ready_n, rd_valid_n, busy_n;
    logic                 spi_cs_n, spi_start_n;
    logic [7:0]           rd_data_n, spi_tx_data_n;

    // State, counters and every output are registered here
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_IDLE;
            phase_cnt   <= '0;
            len_cnt     <= '0;
            hdr         <= '0;
            pending     <= 1'b0;
            req_ready   <= 1'b0;
            wr_ready    <= 1'b0;
            rd_data     <= '0;
            rd_valid    <= 1'b0;
            busy        <= 1'b0;
            spi_cs      <= 1'b0;
            spi_start   <= 1'b0;
            spi_tx_data <= '0;
        end else begin
            state       <= state_n;
            phase_cnt   <= phase_cnt_n;
            len_cnt     <= len_cnt_n;
            hdr         <= hdr_n;
            pending     <= pending_n;
            req_ready   <= req_ready_n;
            wr_ready    <= wr_ready_n;
            rd_data     <= rd_data_n;
            rd_valid    <= rd_valid_n;
            busy        <= busy_n;
            spi_cs      <= spi_cs_n;
            spi_start   <= spi_start_n;
            spi_tx_data <= spi_tx_data_n;
        end
    end

    // Next-state logic; pending tracks an exchange the engine still owes us
    always_comb begin
        state_n       = state;
        phase_cnt_n   = phase_cnt;
        len_cnt_n     = len_cnt;
        hdr_n         = hdr;
        pending_n     = pending;
        req_ready_n   = req_ready;
        wr_ready_n    = 1'b0;
        rd_data_n     = rd_data;
        rd_valid_n    = 1'b0;
        busy_n        = busy;
        spi_cs_n      = spi_cs;
        spi_start_n   = 1'b0;
        spi_tx_data_n = spi_tx_data;

        if (pending && spi_done) begin
            pending_n = 1'b0;
        end

        case (state)
            ST_IDLE: begin
                req_ready_n = 1'b1;
                if (req_valid && req_ready) begin
                    hdr_n.write = req_write;
                    hdr_n.addr  = PROTO_ADDR_BITS'(req_addr);
                    len_cnt_n   = req_len;
                    phase_cnt_n = '0;
                    req_ready_n = 1'b0;
                    busy_n      = 1'b1;
                    spi_cs_n    = 1'b1;
                    state_n     = ST_CS_SETUP;
                end
            end
            ST_CS_SETUP: begin
                if (phase_cnt == CNT_W'(CS_SETUP_CYCLES - 1)) begin
                    phase_cnt_n = '0;
                    state_n     = ST_ADDR_HI;
                end else begin
                    phase_cnt_n = phase_cnt + CNT_W'(1);
                end
            end
            ST_ADDR_HI: begin
                if (!pending) begin
                    spi_start_n   = 1'b1;
                    spi_tx_data_n = proto_byte0(hdr);
                    pending_n     = 1'b1;
                end else if (spi_done) begin
                    state_n = ST_ADDR_LO;
                end
            end
            ST_ADDR_LO: begin
                if (!pending) begin
                    spi_start_n   = 1'b1;
                    spi_tx_data_n = proto_byte1(hdr);
                    pending_n     = 1'b1;
                end else if (spi_done) begin
                    state_n = hdr.write ? ST_DATA : ST_DUMMY;
                end
            end
            ST_DUMMY: begin
                if (!pending) begin
                    spi_start_n   = 1'b1;
                    spi_tx_data_n = DUMMY_BYTE;
                    pending_n     = 1'b1;
                end else if (spi_done) begin
                    state_n = ST_DATA;
                end
            end
            ST_DATA: begin
                if (!pending) begin
                    if (!hdr.write) begin
                        spi_start_n   = 1'b1;
                        spi_tx_data_n = DUMMY_BYTE;
                        pending_n     = 1'b1;
                    end else if (wr_valid) begin
                        spi_start_n   = 1'b1;
                        spi_tx_data_n = wr_data;
                        wr_ready_n    = 1'b1;
                        pending_n     = 1'b1;
                    end
                end else if (spi_done) begin
                    if (!hdr.write) begin
                        rd_data_n  = spi_rx_data;
                        rd_valid_n = 1'b1;
                    end
                    if (len_cnt == '0) begin
                        spi_cs_n    = 1'b0;
                        phase_cnt_n = '0;
                        state_n     = ST_CS_GAP;
                    end else begin
                        len_cnt_n = len_cnt - LEN_WIDTH'(1);
                    end
                end
            end
            ST_CS_GAP: begin
                if (phase_cnt == CNT_W'(CS_IDLE_CYCLES - 1)) begin
                    phase_cnt_n = '0;
                    busy_n      = 1'b0;
                    req_ready_n = 1'b1;
                    state_n     = ST_IDLE;
                end else begin
                    phase_cnt_n = phase_cnt + CNT_W'(1);
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_spi_memory_initiator.sv
// Randomised and directed bench for spi_memory_initiator with a byte-engine
// responder and a burst-level reference model.
module tb_spi_memory_initiator;

    localparam int unsigned AW    = 13;
    localparam int unsigned LW    = 8;
    localparam int unsigned SETUP = 2;
    localparam int unsigned GAP   = 4;

    logic          clk, rst;
    logic          req_valid, req_ready, req_write;
    logic [AW-1:0] req_addr;
    logic [LW-1:0] req_len;
    logic [7:0]    wr_data, rd_data, spi_tx_data, spi_rx_data;
    logic          wr_valid, wr_ready, rd_valid, busy, spi_cs, spi_start, spi_done;

    spi_memory_initiator #(
        .ADDRESS_WIDTH(AW), .LEN_WIDTH(LW),
        .CS_SETUP_CYCLES(SETUP), .CS_IDLE_CYCLES(GAP)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_len(req_len),
        .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy),
        .spi_cs(spi_cs), .spi_start(spi_start), .spi_tx_data(spi_tx_data),
        .spi_rx_data(spi_rx_data), .spi_done(spi_done)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Byte-exchange engine: answers each start with done after a delay
    int         eng_cnt   = 0;
    int         eng_delay = 8;
    bit         eng_rand  = 1'b0;
    logic [7:0] rx_q[$];

    initial begin
        spi_done    = 1'b0;
        spi_rx_data = 8'h00;
        forever begin
            @(posedge clk); #1;
            spi_done = 1'b0;
            if (eng_cnt > 0) begin
                eng_cnt--;
                if (eng_cnt == 0) begin
                    spi_done = 1'b1;
                    if (rx_q.size() > 0) spi_rx_data = rx_q.pop_front();
                    else                 spi_rx_data = 8'($urandom);
                end
            end else if (spi_start) begin
                eng_cnt = eng_rand ? int'($urandom_range(1, 10)) : eng_delay;
            end
        end
    end

    // Write-data source with optional stall after a given number of bytes
    logic [7:0] wr_q[$];
    int pop_cnt = 0, stall_at = -1, stall_len = 0, stall_cnt = 0;

    initial begin
        wr_valid = 1'b0;
        wr_data  = 8'h00;
        forever begin
            @(posedge clk); #1;
            if (wr_ready && wr_q.size() > 0) begin
                void'(wr_q.pop_front());
                pop_cnt++;
                if (pop_cnt == stall_at) stall_cnt = stall_len;
            end
            if (stall_cnt > 0) begin
                stall_cnt--;
                wr_valid = 1'b0;
            end else if (wr_q.size() > 0) begin
                wr_valid = 1'b1;
                wr_data  = wr_q[0];
            end else begin
                wr_valid = 1'b0;
            end
        end
    end

    // Reference model and per-cycle compare
    logic [7:0] exp_tx[$], exp_wr_q[$], tx_log[$], rd_log[$];
    bit         m_open, m_out, m_out_rd, m_rd_due, m_w, m_had_burst, m_prev_cs, m_last_wrv, exp_wr;
    logic [7:0] m_rd_val;
    int         m_total, m_len, m_nstart, m_ndone, m_nwr, m_cs_hi, m_cs_lo, wr_total, m_addr;

    initial begin
        m_open = 0; m_out = 0; m_out_rd = 0; m_rd_due = 0; m_w = 0; m_had_burst = 0;
        m_prev_cs = 0; m_last_wrv = 0; m_rd_val = 0; m_total = 0; m_len = 0;
        m_nstart = 0; m_ndone = 0; m_nwr = 0; m_cs_hi = 0; m_cs_lo = 0; wr_total = 0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                check_eq("reset_outputs",
                         {req_ready, wr_ready, rd_valid, busy, spi_cs, spi_start, rd_data, spi_tx_data}, 0);
                m_open = 0; m_out = 0; m_rd_due = 0; m_had_burst = 0; m_prev_cs = 0;
                m_cs_hi = 0; m_cs_lo = 0;
                exp_tx.delete();
                continue;
            end
            check_eq("rd_valid", rd_valid, m_rd_due);
            if (m_rd_due) check_eq("rd_data", rd_data, m_rd_val);
            if (rd_valid) rd_log.push_back(rd_data);
            m_rd_due = 0;

            exp_wr = spi_start && m_open && m_w && (m_nstart >= 2);
            check_eq("wr_ready", wr_ready, exp_wr);
            if (wr_ready) begin
                wr_total++;
                m_nwr++;
            end
            check_eq("ready_busy_exclusive", req_ready && busy, 0);
            check_eq("cs_without_busy", spi_cs && !busy, 0);
            if (m_open) begin
                check_eq("busy_in_burst", busy, 1);
                check_eq("cs_held_in_burst", spi_cs, 1);
            end
            if (spi_cs && !m_prev_cs && m_had_burst) check_eq("cs_low_gap", m_cs_lo >= GAP, 1);

            if (spi_start) begin
                check_eq("start_in_burst", m_open && (m_nstart < m_total), 1);
                check_eq("start_overlap", m_out, 0);
                check_eq("cs_at_start", spi_cs, 1);
                if (m_nstart == 0) check_eq("cs_setup_time", m_cs_hi >= SETUP, 1);
                if (exp_wr) check_eq("start_without_wr_valid", m_last_wrv, 1);
                if (exp_tx.size() > 0) check_eq("spi_tx_data", spi_tx_data, exp_tx.pop_front());
                tx_log.push_back(spi_tx_data);
                m_out    = 1;
                m_out_rd = !m_w && (m_nstart >= 3);
                m_nstart++;
            end

            if (spi_done && m_out) begin
                m_out = 0;
                m_ndone++;
                if (m_out_rd) begin
                    m_rd_due = 1;
                    m_rd_val = spi_rx_data;
                end
                if (m_ndone == m_total) begin
                    m_open      = 0;
                    m_had_burst = 1;
                    check_eq("burst_start_count", m_nstart, m_total);
                    check_eq("burst_wr_pulses", m_nwr, m_w ? m_len + 1 : 0);
                end
            end

            m_cs_hi = spi_cs ? m_cs_hi + 1 : 0;
            m_cs_lo = spi_cs ? 0 : m_cs_lo + 1;

            if (req_valid && req_ready) begin
                check_eq("accept_when_idle", m_open, 0);
                m_open   = 1;
                m_w      = req_write;
                m_len    = int'(req_len);
                m_addr   = int'(req_addr);
                m_nstart = 0;
                m_ndone  = 0;
                m_nwr    = 0;
                m_out    = 0;
                m_total  = 3 + (req_write ? 0 : 1) + m_len;
                exp_tx.delete();
                exp_tx.push_back(8'((req_write ? 128 : 0) + ((m_addr >> 8) & 127)));
                exp_tx.push_back(8'(m_addr & 255));
                if (!req_write) exp_tx.push_back(8'h00);
                for (int i = 0; i <= m_len; i++) begin
                    if (req_write && exp_wr_q.size() > 0) exp_tx.push_back(exp_wr_q.pop_front());
                    else                                  exp_tx.push_back(8'h00);
                end
            end
            m_last_wrv = wr_valid;
            m_prev_cs  = spi_cs;
        end
    end

    task automatic send_req(input bit w, input int addr, input int len, input bit keep_valid);
        int n;
        bit got;
        req_write = w;
        req_addr  = AW'(addr);
        req_len   = LW'(len);
        req_valid = 1'b1;
        n   = 0;
        got = 1'b0;
        while (!got && n < 5000) begin
            got = req_ready;
            @(posedge clk); #1;
            n++;
        end
        check_eq("req_accepted", got, 1);
        if (!keep_valid) req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((m_open || busy) && n < 20000) begin
            @(posedge clk); #1;
            n++;
        end
        check_eq("idle_reached", m_open || busy, 0);
    endtask

    task automatic push_wr(input logic [7:0] b);
        wr_q.push_back(b);
        exp_wr_q.push_back(b);
    endtask

    task automatic check_log(input string name, input logic [7:0] act[$], input logic [7:0] exp[$]);
        check_eq({name, "_len"}, act.size(), exp.size());
        for (int i = 0; i < exp.size(); i++) begin
            if (i < act.size()) check_eq(name, act[i], exp[i]);
        end
    endtask

    task automatic clear_logs();
        tx_log.delete();
        rd_log.delete();
        wr_total = 0;
        pop_cnt  = 0;
    endtask

    logic [7:0] eq[$];

    initial begin
        int n;
        bit w;
        int addr, len;
        rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_len = '0;
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;

        // Write burst: header byte 0 carries the write flag in bit 7
        clear_logs();
        push_wr(8'hAA); push_wr(8'hBB); push_wr(8'hCC);
        send_req(1'b1, 'h0123, 2, 1'b0);
        wait_idle();
        eq = '{8'h81, 8'h23, 8'hAA, 8'hBB, 8'hCC};
        check_log("t1_tx", tx_log, eq);
        check_eq("t1_wr_pulses", wr_total, 3);

        // Read burst: dummy-byte response is discarded
        clear_logs();
        rx_q = '{8'hE1, 8'hE2, 8'h55, 8'h11, 8'h22};
        send_req(1'b0, 'h1FFF, 1, 1'b0);
        wait_idle();
        eq = '{8'h1F, 8'hFF, 8'h00, 8'h00, 8'h00};
        check_log("t2_tx", tx_log, eq);
        eq = '{8'h11, 8'h22};
        check_log("t2_rd", rd_log, eq);

        // Write stall of 20 cycles before the second data byte
        clear_logs();
        stall_at = 1; stall_len = 20;
        push_wr(8'h11); push_wr(8'h22); push_wr(8'h33);
        send_req(1'b1, 'h0040, 2, 1'b0);
        wait_idle();
        stall_at = -1;
        eq = '{8'h80, 8'h40, 8'h11, 8'h22, 8'h33};
        check_log("t3_tx", tx_log, eq);

        // Back-to-back with req_valid held high across both requests
        clear_logs();
        push_wr(8'h5A); push_wr(8'hA5);
        send_req(1'b1, 'h0A0A, 1, 1'b1);
        send_req(1'b0, 'h1234, 2, 1'b0);
        wait_idle();
        eq = '{8'h8A, 8'h0A, 8'h5A, 8'hA5, 8'h12, 8'h34, 8'h00, 8'h00, 8'h00, 8'h00};
        check_log("t4_tx", tx_log, eq);
        check_eq("t4_rd_count", rd_log.size(), 3);

        // Reset during the first data byte
        clear_logs();
        push_wr(8'h01); push_wr(8'h02); push_wr(8'h03); push_wr(8'h04);
        send_req(1'b1, 'h0555, 3, 1'b0);
        n = 0;
        while (tx_log.size() < 3 && n < 1000) begin
            @(posedge clk); #1;
            n++;
        end
        check_eq("t5_reached_data", tx_log.size() >= 3, 1);
        @(posedge clk); #3;
        rst = 1'b0;
        #1;
        check_eq("t5_async_reset",
                 {req_ready, wr_ready, rd_valid, busy, spi_cs, spi_start, rd_data, spi_tx_data}, 0);
        wr_q.delete();
        exp_wr_q.delete();
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        repeat (15) @(posedge clk);
        #1;
        clear_logs();
        send_req(1'b0, 'h0000, 0, 1'b0);
        wait_idle();
        eq = '{8'h00, 8'h00, 8'h00, 8'h00};
        check_log("t5_tx", tx_log, eq);
        check_eq("t5_rd_count", rd_log.size(), 1);

        // Maximum-length write burst
        clear_logs();
        for (int i = 0; i < 256; i++) push_wr(8'($urandom));
        send_req(1'b1, $urandom_range(0, 8191), 255, 1'b0);
        wait_idle();
        check_eq("t6_wr_pulses", wr_total, 256);
        check_eq("t6_start_count", tx_log.size(), 258);

        // Randomised bursts with variable engine latency and write stalls
        eng_rand = 1'b1;
        for (int i = 0; i < 25; i++) begin
            clear_logs();
            w    = 1'($urandom_range(0, 1));
            addr = int'($urandom_range(0, 8191));
            len  = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(0, 9));
            stall_at = -1;
            if (w) begin
                for (int j = 0; j <= len; j++) push_wr(8'($urandom));
                if (len > 0 && $urandom_range(0, 1) == 1) begin
                    stall_at  = int'($urandom_range(1, len));
                    stall_len = int'($urandom_range(1, 6));
                end
            end
            send_req(w, addr, len, 1'b0);
            wait_idle();
            check_eq("rand_start_count", tx_log.size(), 3 + (w ? 0 : 1) + len);
            check_eq("rand_rd_count", rd_log.size(), w ? 0 : len + 1);
        end
        stall_at = -1;

        repeat (5) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
